fir_out_formatter: RTL and testbench
====================================

// Module: fir_out_formatter
// PURPOSE
// - Sink-side companion of the 64-tap FIR: accepts the 32-bit Q2.30 accumulator output
//   (yout) every valid cycle and converts it back to a 16-bit Q1.15 sample stream.
// - Applies round-half-up and saturation, optional decimation by DECIM, and buffers
//   results in a FIFO.
// - Drives a valid/ready interface toward DAC/serializer logic; reports saturation and overflow.
// PARAMETERS
// - DECIM       default 1   keep 1 of every DECIM accepted samples; legal range 1..16
// - FIFO_DEPTH  default 8   output FIFO entries; power of two, 2..64
// - CNT_W       default 4   decimation counter width; must satisfy 2^CNT_W >= DECIM
// PORTS
// - clk         in   1                   rising-edge clock
// - reset       in   1                   asynchronous, active-low reset
// - yin         in   32                  signed Q2.30 FIR accumulator sample
// - yin_valid   in   1                   yin is a new sample this cycle; no backpressure on this side
// - dout        out  16                  signed Q1.15 sample at FIFO head
// - dout_valid  out  1                   FIFO not empty
// - dout_ready  in   1                   consumer accepts dout this cycle
// - fill_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// - sat_flag    out  1                   sticky; a sample was clipped
// - ovf_flag    out  1                   sticky; a sample was dropped because the FIFO was full
// - clr_flags   in   1                   synchronous clear of sat_flag and ovf_flag
// BEHAVIOUR
// - Reset (reset=0, async)
//   - All outputs 0: dout=0, dout_valid=0, fill_level=0, sat_flag=0, ovf_flag=0.
//   - FIFO pointers, decimation counter and stage-1 register clear.
//   - Reset mid-stream discards all buffered data; no partial sample survives.
// - Stage 1 (registered, 1 cycle)
//   - r = yin + 32'sh4000, computed 33-bit signed.
//   - q = r >>> 15 (arithmetic); q > 32767 -> 16'h7FFF; q < -32768 -> 16'h8000.
//   - Stage-1 valid register s1_v <= yin_valid.
// - Decimation counter
//   - Advances only on s1_v=1; wraps at DECIM-1 -> 0.
//   - Push asserted when s1_v=1 and count==DECIM-1, i.e. the DECIM-th, 2*DECIM-th ... sample.
//   - DECIM=1: every sample pushed.
//   - sat_flag sets on any clipped stage-1 sample, including samples that decimation discards.
// - FIFO (first-word-fall-through)
//   - dout = mem[rd_ptr]; dout_valid = (fill_level != 0).
//   - Pop on dout_valid & dout_ready.
//   - Latency: yin_valid at edge N -> dout_valid at edge N+2 when the FIFO was empty.
//   - Full with push and no pop: sample dropped, ovf_flag set, FIFO contents unchanged.
//   - Full with push and pop in the same cycle: both happen, fill_level stays FIFO_DEPTH,
//     no overflow.
//   - Empty with dout_ready=1: no pop, pointers hold, dout holds last mem value.
//   - Pointers wrap modulo FIFO_DEPTH; fill_level never exceeds FIFO_DEPTH.
// - Flags
//   - clr_flags=1 clears both flags at the next edge.
//   - If a set event occurs in the same cycle as clr_flags, the set wins.
// CONFIGURATION
// - FIR_OUT_SAT_EN defined: saturation and sat_flag operate as specified in BEHAVIOUR.
// - FIR_OUT_SAT_EN undefined: no clipping; dout = r[30:15] (two's-complement wrap);
//   sat_flag tied to 0.
// TESTING
// - Rounding: DECIM=1, yin=32'h0000_4000 -> dout=16'h0001; yin=32'hFFFF_C000 -> dout=16'h0000;
//   each appears 2 cycles after yin_valid.
// - Saturation (FIR_OUT_SAT_EN): yin=32'h3FFF_C000 -> 16'h7FFF and sat_flag=1;
//   yin=32'h8000_0000 -> 16'h8000. Then clr_flags=1 -> sat_flag=0.
// - Decimation: DECIM=4, eight consecutive samples yin=k<<15, k=1..8 -> only dout=4 and dout=8
//   emerge, in order.
// - Overflow: FIFO_DEPTH=8, dout_ready=0, push 10 samples -> fill_level=8, ovf_flag=1;
//   then drain -> first 8 values in order.
// - Full push+pop: FIFO full, dout_ready=1 and push in the same cycle -> fill_level stays 8,
//   ovf_flag stays 0, data order preserved.
// - Reset mid-stream: assert reset with fill_level=5 -> all outputs 0 immediately (async);
//   after release the first new sample appears at dout 2 cycles after yin_valid.

Source files
------------

// File: rtl/fir_out_formatter_if.sv
// Bus bundle for fir_out_formatter: sample input, FIFO output handshake, status flags.
// The master side feeds samples and consumes dout; the slave side is the formatter.
interface fir_out_formatter_if #(
  parameter int unsigned FIFO_DEPTH = 8
) ();
  localparam int unsigned FILL_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       yin;
  logic              yin_valid;
  logic [15:0]       dout;
  logic              dout_valid;
  logic              dout_ready;
  logic [FILL_W-1:0] fill_level;
  logic              sat_flag;
  logic              ovf_flag;
  logic              clr_flags;

  modport master (
    output yin, yin_valid, dout_ready, clr_flags,
    input  dout, dout_valid, fill_level, sat_flag, ovf_flag
  );

  modport slave (
    input  yin, yin_valid, dout_ready, clr_flags,
    output dout, dout_valid, fill_level, sat_flag, ovf_flag
  );
endinterface

// File: rtl/fir_out_formatter.sv
// fir_out_formatter: Q2.30 FIR accumulator -> Q1.15 sample stream.
// Round-half-up, optional saturation, decimation by DECIM, FWFT output FIFO.
// Optional feature macro: FIR_OUT_SAT_EN (clip to Q1.15 range and report via sat_flag);
// when undefined the result wraps (r[30:15]) and sat_flag stays 0.
module fir_out_formatter #(
  parameter int unsigned DECIM      = 1,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fir_out_formatter_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FIFO_DEPTH);

  logic              s1_v_q, s1_v_d;
  logic [15:0]       s1_data_q, s1_data_d;
  logic              s1_clip_q, s1_clip_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       mem_q [FIFO_DEPTH];
  logic [15:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              sat_q, sat_d;
  logic              ovf_q, ovf_d;

  logic [32:0]       r_c;
  logic [15:0]       q_c;
  logic              clip_c;
  logic              push_c, pop_c, full_c, wr_en_c;
  logic              unused_c;

  // Round-half-up in 33 bits, then clip or wrap down to 16 bits
  always_comb begin
    r_c    = {bus.yin[31], bus.yin} + 33'h0_0000_4000;
    clip_c = 1'b0;
`ifdef FIR_OUT_SAT_EN
    q_c = r_c[30:15];
    if ((r_c[32] != r_c[31]) || (r_c[32] != r_c[30])) begin
      clip_c = 1'b1;
      q_c    = r_c[32] ? 16'h8000 : 16'h7FFF;
    end
    unused_c = ^r_c[14:0];
`else
    q_c      = r_c[30:15];
    unused_c = ^{r_c[32:31], r_c[14:0]};
`endif
  end

  // Next-state for stage 1, decimation, FIFO and sticky flags
  always_comb begin
    s1_v_d    = bus.yin_valid;
    s1_data_d = q_c;
    s1_clip_d = clip_c;

    push_c  = s1_v_q && (cnt_q == CNT_LAST);
    pop_c   = (fill_q != '0) && bus.dout_ready;
    full_c  = (fill_q == FILL_FULL);
    wr_en_c = push_c && (!full_c || pop_c);

    cnt_d = cnt_q;
    if (s1_v_q) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    mem_d = mem_q;
    if (wr_en_c) begin
      mem_d[wr_ptr_q] = s1_data_q;
    end

    wr_ptr_d = wr_en_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    fill_d = fill_q;
    unique case ({wr_en_c, pop_c})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase

    // A set event in the clearing cycle wins over the clear
    sat_d = (sat_q && !bus.clr_flags) || (s1_v_q && s1_clip_q);
    ovf_d = (ovf_q && !bus.clr_flags) || (push_c && full_c && !pop_c);
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_clip_q <= 1'b0;
      cnt_q     <= '0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s1_clip_q <= s1_clip_d;
      cnt_q     <= cnt_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      sat_q     <= sat_d;
      ovf_q     <= ovf_d;
    end
  end

  // Outputs come straight from registers (FWFT head of FIFO)
  assign bus.dout       = mem_q[rd_ptr_q];
  assign bus.dout_valid = (fill_q != '0);
  assign bus.fill_level = fill_q;
  assign bus.sat_flag   = sat_q;
  assign bus.ovf_flag   = ovf_q;
endmodule

// File: tb/tb_fir_out_formatter.sv
// Self-checking bench for fir_out_formatter: a DECIM=1 instance checked every cycle
// against a queue-based model, plus a DECIM=4 instance sharing the same input stream.
module tb_fir_out_formatter;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_out_formatter_if #(.FIFO_DEPTH(DEPTH)) if0 ();
  fir_out_formatter_if #(.FIFO_DEPTH(DEPTH)) if1 ();

  fir_out_formatter #(.DECIM(1), .FIFO_DEPTH(DEPTH), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave)
  );
  fir_out_formatter #(.DECIM(4), .FIFO_DEPTH(DEPTH), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );

  assign if1.yin        = if0.yin;
  assign if1.yin_valid  = if0.yin_valid;
  assign if1.dout_ready = 1'b1;
  assign if1.clr_flags  = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mq[$];
  logic [15:0] exp4[$];
  logic [15:0] got4[$];
  bit          pend_v, pend_clip;
  logic [15:0] pend_val;
  bit          sat_m, ovf_m;
  int          dec_m;

  // Collect every word the always-ready DECIM=4 instance hands out
  always @(negedge clk) begin
    if (reset && if1.dout_valid) got4.push_back(if1.dout);
  end

  function automatic logic [15:0] fmt(input logic [31:0] y, output bit clip);
    longint r, q;
    r = longint'($signed(y)) + 64'sd16384;
    q = r >>> 15;
    clip = 1'b0;
`ifdef FIR_OUT_SAT_EN
    if (q > 64'sd32767) begin clip = 1'b1; return 16'h7FFF; end
    if (q < -64'sd32768) begin clip = 1'b1; return 16'h8000; end
`endif
    return 16'(q);
  endfunction

  function automatic logic [31:0] rand_y();
    logic [31:0] y;
    y = $urandom;
    case ($urandom_range(0, 2))
      0: y = $urandom;
      1: y[31:30] = {y[29], y[29]};
      default: y = 32'h3FFF_BFFE + 32'($urandom_range(0, 3));
    endcase
    return y;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge
  task automatic tick(input bit v, input logic [31:0] y, input bit rdy, input bit clr);
    bit pop, full, c;
    logic [15:0] f;
    if0.yin = y; if0.yin_valid = v; if0.dout_ready = rdy; if0.clr_flags = clr;
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == DEPTH);
    if (clr) begin sat_m = 1'b0; ovf_m = 1'b0; end
    if (pend_v && pend_clip) sat_m = 1'b1;
    if (pop) f = mq.pop_front();
    if (pend_v) begin
      if (full && !pop) ovf_m = 1'b1;
      else mq.push_back(pend_val);
    end
    f = fmt(y, c);
    pend_v = v; pend_val = f; pend_clip = c;
    if (v) begin
      dec_m++;
      if (dec_m == 4) begin exp4.push_back(f); dec_m = 0; end
    end
    @(posedge clk);
    @(negedge clk);
    chk("dout_valid", 32'(if0.dout_valid), 32'(mq.size() != 0));
    chk("fill_level", 32'(if0.fill_level), 32'(mq.size()));
    if (mq.size() != 0) chk("dout", 32'(if0.dout), 32'(mq[0]));
    chk("sat_flag", 32'(if0.sat_flag), 32'(sat_m));
    chk("ovf_flag", 32'(if0.ovf_flag), 32'(ovf_m));
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0, rdy, 1'b0);
  endtask

  task automatic cmp4();
    int n;
    #2;
    chk("dec_count", 32'(got4.size()), 32'(exp4.size()));
    n = (got4.size() < exp4.size()) ? got4.size() : exp4.size();
    for (int i = 0; i < n; i++) chk("dec_data", 32'(got4[i]), 32'(exp4[i]));
    got4.delete();
    exp4.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_dout", 32'(if0.dout), 32'h0);
    chk("rst_valid", 32'(if0.dout_valid), 32'h0);
    chk("rst_fill", 32'(if0.fill_level), 32'h0);
    chk("rst_sat", 32'(if0.sat_flag), 32'h0);
    chk("rst_ovf", 32'(if0.ovf_flag), 32'h0);
    chk("rst_valid4", 32'(if1.dout_valid), 32'h0);
    mq.delete(); exp4.delete(); got4.delete();
    pend_v = 1'b0; sat_m = 1'b0; ovf_m = 1'b0; dec_m = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    if0.yin = '0; if0.yin_valid = 1'b0; if0.dout_ready = 1'b0; if0.clr_flags = 1'b0;
    reset = 1'b1;
    pend_v = 1'b0; pend_clip = 1'b0; pend_val = '0;
    sat_m = 1'b0; ovf_m = 1'b0; dec_m = 0;
    @(negedge clk);
    do_reset();

    // Rounding: +0.5 LSB rounds up, -0.5 LSB rounds to zero
    tick(1'b1, 32'h0000_4000, 1'b1, 1'b0);
    tick(1'b1, 32'hFFFF_C000, 1'b1, 1'b0);
    chk("round_up", 32'(if0.dout), 32'h0001);
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    chk("round_half_neg", 32'(if0.dout), 32'h0000);
    idle(2, 1'b1);

    // Saturation at both rails, then clear
    tick(1'b1, 32'h3FFF_C000, 1'b1, 1'b0);
    tick(1'b1, 32'h8000_0000, 1'b1, 1'b0);
`ifdef FIR_OUT_SAT_EN
    chk("sat_pos", 32'(if0.dout), 32'h7FFF);
    chk("sat_flag_set", 32'(if0.sat_flag), 32'h1);
`else
    chk("wrap_pos", 32'(if0.dout), 32'h8000);
`endif
    tick(1'b0, 32'h0, 1'b1, 1'b0);
`ifdef FIR_OUT_SAT_EN
    chk("sat_neg", 32'(if0.dout), 32'h8000);
`else
    chk("wrap_neg", 32'(if0.dout), 32'h0000);
`endif
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    chk("sat_flag_clr", 32'(if0.sat_flag), 32'h0);
    idle(2, 1'b1);
    cmp4();

    // Decimation by 4: k<<15 for k=1..8 yields only 4 and 8
    for (int k = 1; k <= 8; k++) tick(1'b1, 32'(k) << 15, 1'b1, 1'b0);
    idle(3, 1'b1);
    #1;
    chk("dec_n", 32'(got4.size()), 32'd2);
    if (got4.size() == 2) begin
      chk("dec_first", 32'(got4[0]), 32'd4);
      chk("dec_second", 32'(got4[1]), 32'd8);
    end
    cmp4();

    // Overflow: ten pushes into an 8-deep FIFO with no consumer
    for (int i = 0; i < 10; i++) tick(1'b1, rand_y(), 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("ovf_fill", 32'(if0.fill_level), 32'd8);
    chk("ovf_flag_set", 32'(if0.ovf_flag), 32'h1);
    idle(9, 1'b1);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    chk("ovf_flag_clr", 32'(if0.ovf_flag), 32'h0);
    cmp4();

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 9; i++) tick(1'b1, rand_y(), 1'b0, 1'b0);
    chk("full_fill", 32'(if0.fill_level), 32'd8);
    for (int i = 0; i < 4; i++) tick(1'b1, rand_y(), 1'b1, 1'b0);
    chk("pushpop_fill", 32'(if0.fill_level), 32'd8);
    chk("pushpop_ovf", 32'(if0.ovf_flag), 32'h0);
    idle(10, 1'b1);
    cmp4();

    // Randomized traffic, backpressure and flag clears
    for (int i = 0; i < 300; i++)
      tick(1'($urandom_range(0, 3) != 0), rand_y(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));
    idle(12, 1'b1);
    cmp4();

    // Reset mid-stream with five words buffered
    for (int i = 0; i < 5; i++) tick(1'b1, rand_y(), 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("pre_rst_fill", 32'(if0.fill_level), 32'd5);
    do_reset();
    tick(1'b1, 32'h0001_8000, 1'b1, 1'b0);
    chk("post_rst_lat1", 32'(if0.dout_valid), 32'h0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    chk("post_rst_valid", 32'(if0.dout_valid), 32'h1);
    chk("post_rst_dout", 32'(if0.dout), 32'h0003);
    idle(4, 1'b1);
    cmp4();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
